viterbi_rse_feeder: RTL

Upstream sequencer for the Viterbi core. It accepts full frames of N_LANES residual-error (RSE) samples from the FFE/channel-subtraction datapath and serializes them into B_LEN-wide chunks, one chunk per cycle, on the core's `rse_vals` input. It also generates the core's `update` / `initialize` / `run` control sequence, so a channel-estimate reload is applied only on a frame boundary. The core's state and branch precomputations therefore never see a mix of old and new estimates inside one frame.

---
 rtl/viterbi_rse_feeder_if.sv | 28 ++
 rtl/viterbi_rse_feeder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/viterbi_rse_feeder_if.sv
// Frame-in / chunk-out bus between the RSE datapath, the feeder and the Viterbi core.
//   in_frame/in_valid/in_ready : full RSE frame handshake (lane 0 oldest)
//   rse_vals/run               : one B_LEN-sample chunk per cycle to the core
//   update/initialize          : core control sequence around a channel reload
// master drives frames and observes the core side; slave is the feeder.
interface viterbi_rse_feeder_if #(
  parameter int unsigned B_WIDTH = 8,
  parameter int unsigned B_LEN   = 2,
  parameter int unsigned N_LANES = 16
) ();
  logic signed [B_WIDTH-1:0] in_frame [N_LANES];
  logic                      in_valid;
  logic                      in_ready;
  logic signed [B_WIDTH-1:0] rse_vals [B_LEN];
  logic                      update;
  logic                      initialize;
  logic                      run;

  modport master (
    output in_frame, in_valid,
    input  in_ready, rse_vals, update, initialize, run
  );

  modport slave (
    input  in_frame, in_valid,
    output in_ready, rse_vals, update, initialize, run
  );
endinterface

// File: rtl/viterbi_rse_feeder.sv
// Serializes N_LANES-sample RSE frames into B_LEN-sample chunks for the Viterbi
// core and sequences update/initialize/run so a channel reload lands only on a
// frame boundary.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   en        : feeder enable
//   chan_load : one-cycle pulse, new channel estimate is stable at the core
//   bus       : frame input handshake and core-side chunk/control outputs
//   busy      : FSM not idle (registered)
//   stall_cnt : saturating count of RUN cycles starved of input
module viterbi_rse_feeder #(
  parameter int unsigned B_WIDTH    = 8,
  parameter int unsigned B_LEN      = 2,
  parameter int unsigned N_LANES    = 16,
  parameter int unsigned UPD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       chan_load,
  viterbi_rse_feeder_if.slave        bus,
  output logic                       busy,
  output logic [15:0]                stall_cnt
);

  localparam int unsigned NCH = N_LANES / B_LEN;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW  = $clog2(UPD_CYCLES + 1);
  // Chunk 0 goes straight to rse_vals on accept, so only the upper lanes are held.
  localparam int unsigned FL  = (N_LANES > B_LEN) ? (N_LANES - B_LEN) : 1;

  typedef enum logic [2:0] {IDLE, UPDATE, INIT, RUN, DRAIN} state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             upd_cnt, upd_cnt_n;
  logic                      full, full_n;
  logic [KW-1:0]             k, k_n;
  logic                      pend_load, pend_load_n;
  logic                      pend_dis, pend_dis_n;
  logic signed [B_WIDTH-1:0] frame [FL];

  logic in_ready_c;
  logic accept_c;
  logic emit_st_c;
  logic last_c;
  logic adv_c;

  // k is the chunk currently on rse_vals; ready on the last chunk gives no bubble.
  assign last_c     = (k == KW'(NCH - 1));
  assign in_ready_c = (state == RUN) && !pend_load && !pend_dis && (!full || last_c);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign emit_st_c  = (state == RUN) || (state == DRAIN);
  assign adv_c      = emit_st_c && full && !last_c && !accept_c;
  assign bus.in_ready = in_ready_c;

  // Next-state, chunk index and pending-request logic.
  always_comb begin
    state_n     = state;
    upd_cnt_n   = upd_cnt;
    full_n      = full;
    k_n         = k;
    pend_load_n = pend_load;
    pend_dis_n  = pend_dis;

    if (accept_c) begin
      full_n = 1'b1;
      k_n    = '0;
    end else if (emit_st_c && full) begin
      if (last_c) full_n = 1'b0;
      else        k_n    = k + KW'(1);
    end

    case (state)
      IDLE: begin
        if (chan_load && en) begin
          state_n   = UPDATE;
          upd_cnt_n = CW'(UPD_CYCLES);
        end
      end
      UPDATE: begin
        if (!en)                     state_n   = IDLE;
        else if (chan_load)          upd_cnt_n = CW'(UPD_CYCLES);
        else if (upd_cnt == CW'(1))  state_n   = INIT;
        else                         upd_cnt_n = upd_cnt - CW'(1);
      end
      INIT: state_n = RUN;
      RUN: begin
        if (chan_load) pend_load_n = 1'b1;
        if (!en)       pend_dis_n  = 1'b1;
        if (pend_load || pend_dis) state_n = DRAIN;
      end
      DRAIN: begin
        // A load arriving while draining is kept so the new estimate is not lost.
        if (chan_load) pend_load_n = 1'b1;
        if (!full) begin
          pend_load_n = 1'b0;
          pend_dis_n  = 1'b0;
          if (pend_load || chan_load) begin
            state_n   = UPDATE;
            upd_cnt_n = CW'(UPD_CYCLES);
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state, registered core outputs and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      upd_cnt        <= '0;
      full           <= 1'b0;
      k              <= '0;
      pend_load      <= 1'b0;
      pend_dis       <= 1'b0;
      bus.update     <= 1'b0;
      bus.initialize <= 1'b0;
      bus.run        <= 1'b0;
      busy           <= 1'b0;
      stall_cnt      <= '0;
      for (int unsigned j = 0; j < B_LEN; j++) bus.rse_vals[j] <= '0;
    end else begin
      state          <= state_n;
      upd_cnt        <= upd_cnt_n;
      full           <= full_n;
      k              <= k_n;
      pend_load      <= pend_load_n;
      pend_dis       <= pend_dis_n;
      bus.update     <= (state_n == UPDATE);
      bus.initialize <= (state_n == INIT);
      bus.run        <= accept_c || adv_c;
      busy           <= (state_n != IDLE);
      if (accept_c) begin
        for (int unsigned j = 0; j < B_LEN; j++) bus.rse_vals[j] <= bus.in_frame[j];
      end else if (adv_c) begin
        for (int unsigned j = 0; j < B_LEN; j++) bus.rse_vals[j] <= frame[j];
      end
      if ((state == RUN) && !full && !accept_c && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Frame holding register: shifts down one chunk per emitted chunk.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int unsigned i = 0; i < FL; i++) begin
        if (i + B_LEN < N_LANES) frame[i] <= bus.in_frame[i + B_LEN];
      end
    end else if (adv_c) begin
      for (int unsigned i = 0; i < FL; i++) begin
        if (i + B_LEN < FL) frame[i] <= frame[i + B_LEN];
      end
    end
  end

endmodule
